// File: rtl/kb_pkg.sv
// Shared keyboard constants and the buffered key entry layout.
// Used by the key event FIFO and its storage sub-module.
package kb_pkg;

    localparam int KB_CODE_W     = 8;
    localparam int KB_FIFO_DEPTH = 8;
    localparam logic [KB_CODE_W-1:0] KB_BREAK_PREFIX = 8'hF0;

    typedef struct packed {
        logic [KB_CODE_W-1:0] scan;
        logic [KB_CODE_W-1:0] ascii;
    } kb_entry_t;

    localparam int KB_ENTRY_W = $bits(kb_entry_t);

endpackage

// File: rtl/kb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Occupancy is tracked in its own counter so full/empty stay exact at wrap.
module kb_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage write; no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy counter; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_fifo.sv
// Key event buffer: drops breaks, filters typematic repeats,
// and counts make events lost to overflow.
module key_event_fifo
    import kb_pkg::*;
#(
    parameter int DEPTH         = KB_FIFO_DEPTH,
    parameter int FILTER_REPEAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   evt_valid,
    input  logic                   evt_break,
    input  logic [KB_CODE_W-1:0]   evt_scan,
    input  logic [KB_CODE_W-1:0]   evt_ascii,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [KB_CODE_W-1:0]   out_scan,
    output logic [KB_CODE_W-1:0]   out_ascii,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [7:0]             drop_cnt,
    output logic                   overflow
);

    logic [KB_CODE_W-1:0] last_scan;
    logic                 held;
    logic                 is_make;
    logic                 is_break;
    logic                 same_key;
    logic                 repeat_hit;
    logic                 cand;
    logic                 pop;
    logic                 accept;
    logic                 drop;
    kb_entry_t            wr_entry;
    kb_entry_t            rd_entry;

    assign is_make    = evt_valid && !evt_break;
    assign is_break   = evt_valid && evt_break;
    assign same_key   = (evt_scan == last_scan);
    assign repeat_hit = (FILTER_REPEAT != 0) && held && same_key;
    assign cand       = is_make && !repeat_hit;
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign accept     = cand && (!full || pop);
    assign drop       = cand && !accept;

    assign wr_entry.scan  = evt_scan;
    assign wr_entry.ascii = evt_ascii;
    assign out_scan       = rd_entry.scan;
    assign out_ascii      = rd_entry.ascii;

    kb_sync_fifo #(
        .WIDTH (KB_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Track the last pressed key so a held key's repeats can be suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_scan <= '0;
            held      <= 1'b0;
        end else if (cand) begin
            last_scan <= evt_scan;
            held      <= 1'b1;
        end else if (is_break && same_key) begin
            held      <= 1'b0;
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_key_event_fifo.sv
// Self-checking bench for key_event_fifo.
// Directed scenarios plus random traffic against a queue model.
module tb_key_event_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       evt_valid;
    logic       evt_break;
    logic [7:0] evt_scan;
    logic [7:0] evt_ascii;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_scan;
    logic [7:0] out_ascii;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic [7:0] drop_cnt;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [15:0] q[$];
    bit          m_held;
    logic [7:0]  m_last;
    int          m_drop;
    bit          m_ovf;

    key_event_fifo #(.DEPTH(DEPTH), .FILTER_REPEAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .evt_valid (evt_valid),
        .evt_break (evt_break),
        .evt_scan  (evt_scan),
        .evt_ascii (evt_ascii),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_scan  (out_scan),
        .out_ascii (out_ascii),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_held = 1'b0;
        m_last = 8'h00;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit b,
                              input logic [7:0] s, input logic [7:0] a,
                              input bit r);
        bit pop;
        bit cand;
        pop  = (q.size() > 0) && r;
        cand = 1'b0;
        if (v && b) begin
            if (s == m_last) m_held = 1'b0;
        end else if (v) begin
            if (!(m_held && s == m_last)) begin
                cand   = 1'b1;
                m_last = s;
                m_held = 1'b1;
            end
        end
        if (cand && !(q.size() < DEPTH || pop)) begin
            if (m_drop < 255) m_drop++;
            m_ovf = 1'b1;
            cand  = 1'b0;
        end
        if (pop) void'(q.pop_front());
        if (cand) q.push_back({s, a});
    endtask

    task automatic check_all();
        logic [15:0] h;
        h = (q.size() > 0) ? q[0] : 16'h0000;
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_scan", out_scan, h[15:8]);
        chk("out_ascii", out_ascii, h[7:0]);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic step(input bit v, input bit b, input logic [7:0] s,
                        input logic [7:0] a, input bit r);
        @(negedge clk);
        rst       = 1'b0;
        evt_valid = v;
        evt_break = b;
        evt_scan  = s;
        evt_ascii = a;
        out_ready = r;
        model_step(v, b, s, a, r);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input bit with_evt);
        @(negedge clk);
        rst       = 1'b1;
        evt_valid = with_evt;
        evt_break = 1'b0;
        evt_scan  = 8'h77;
        evt_ascii = 8'h78;
        out_ready = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic make(input logic [7:0] s, input logic [7:0] a);
        step(1'b1, 1'b0, s, a, 1'b0);
    endtask

    initial begin
        logic [7:0] last_out;
        logic [7:0] s;
        int         phase_bias;

        rst       = 1'b1;
        evt_valid = 1'b0;
        evt_break = 1'b0;
        evt_scan  = 8'h00;
        evt_ascii = 8'h00;
        out_ready = 1'b0;
        model_clear();

        do_reset(1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_valid", out_valid, 1'b0);

        make(8'h1C, 8'h61);
        chk("first_scan", out_scan, 8'h1C);
        chk("first_ascii", out_ascii, 8'h61);
        chk("first_count", count, 1);

        do_reset(1'b0);
        make(8'h1C, 8'h61);
        make(8'h1C, 8'h61);
        make(8'h1C, 8'h61);
        chk("rep_count", count, 1);
        chk("rep_drop", drop_cnt, 0);
        step(1'b1, 1'b1, 8'h1C, 8'h00, 1'b0);
        make(8'h1C, 8'h61);
        chk("rep_rearm_count", count, 2);

        do_reset(1'b0);
        for (int i = 0; i < 9; i++) make(8'h10 + 8'(i), 8'h41 + 8'(i));
        chk("ovf_full", full, 1'b1);
        chk("ovf_count", count, 8);
        chk("ovf_drop", drop_cnt, 1);
        chk("ovf_flag", overflow, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", out_scan, 8'h10 + 8'(i));
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        end
        chk("drain_empty", empty, 1'b1);

        do_reset(1'b0);
        for (int i = 0; i < 8; i++) make(8'h20 + 8'(i), 8'h50 + 8'(i));
        step(1'b1, 1'b0, 8'h32, 8'h33, 1'b1);
        chk("pp_count", count, 8);
        chk("pp_drop", drop_cnt, 0);
        last_out = 8'h00;
        for (int i = 0; i < 8; i++) begin
            last_out = out_scan;
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        end
        chk("pp_last", last_out, 8'h32);

        do_reset(1'b0);
        for (int i = 0; i < 308; i++) begin
            make(8'h50 + 8'(i % 2), 8'h70);
        end
        chk("sat_drop", drop_cnt, 8'hFF);
        chk("sat_ovf", overflow, 1'b1);

        do_reset(1'b0);
        for (int i = 0; i < 5; i++) make(8'h60 + 8'(i), 8'h30 + 8'(i));
        chk("mid_count", count, 5);
        do_reset(1'b1);
        chk("mid_empty", empty, 1'b1);
        chk("mid_valid", out_valid, 1'b0);
        chk("mid_drop", drop_cnt, 0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("mid_stray", count, 0);

        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            phase_bias = (i / 250) % 3;
            case ($urandom_range(0, 4))
                0: s = 8'h1C;
                1: s = 8'h1D;
                2: s = 8'h2A;
                3: s = 8'h3B;
                default: s = 8'($urandom);
            endcase
            step(($urandom % 3) != 0, ($urandom % 4) == 0, s,
                 8'($urandom),
                 phase_bias == 0 ? ($urandom % 4) == 0 :
                 phase_bias == 1 ? ($urandom % 4) != 0 :
                 ($urandom % 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
